ref_entry: RTL and testbench
============================

Name: ref_entry

Overview:
Pushbutton front end that produces the 8-bit servo reference and the one-cycle send strobe consumed by the reference register/display block. It debounces five board buttons, lets the operator edit the value one decimal digit at a time (hundreds, tens or units), saturates the value to 0..MAX_REF, and issues a send pulse on OK. It drives ref_in/enviar of the reference path and feeds digit_sel to the display enable for cursor indication.

Parameters:
DEB_CYCLES, 500000, clk cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz).
HOLD_CYCLES, 16, post-send lockout length in clk cycles.
MAX_REF, 255, upper saturation limit of ref_val (must be <= 255).
INIT_REF, 0, value loaded into ref_val on reset.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_up  input  1  raw button, async, active-high: add weight of selected digit
btn_down  input  1  raw button: subtract weight of selected digit
btn_left  input  1  raw button: move cursor toward hundreds
btn_right  input  1  raw button: move cursor toward units
btn_ok  input  1  raw button: send current value
ref_val  output  8  edited reference value, drives ref_in
enviar  output  1  one-cycle send strobe
digit_sel  output  3  one-hot cursor {cent,dec,uni}
busy  output  1  high during SEND and HOLD

Behaviour:
- Reset (async, rst=1): ref_val=INIT_REF, enviar=0, digit_sel=3'b001 (units), busy=0, FSM=IDLE, all synchronizers/debounce counters/debounced levels cleared to 0.
- Per button: 2-FF synchronizer -> counter restarts on any change of synchronized level; when stable for DEB_CYCLES consecutive cycles the debounced level takes the new value. Event = one-cycle pulse on debounced 0->1 transition. Release edges generate nothing. Press-to-event latency = 2 + DEB_CYCLES + 1 cycles.
- FSM states:
  IDLE: processes events; busy=0.
  SEND: entered on ok event; enviar=1 for exactly this one cycle; busy=1; next HOLD.
  HOLD: busy=1; counts HOLD_CYCLES; returns to IDLE only when count done AND debounced ok level is 0; all events dropped.
- Event priority in IDLE when several fire in the same cycle: ok > up > down > left > right; only the highest is acted on, others discarded (no queueing).
- up: weight w = 100/10/1 per digit_sel; ref_val = min(ref_val + w, MAX_REF). Arithmetic in 9 bits, no wrap.
- down: ref_val = max(ref_val - w, 0); no wrap below 0.
- left: cursor uni->dec->cent; at cent stays at cent (no wrap). right: cent->dec->uni; at uni stays.
- ref_val updates the cycle after the event; ref_val is stable (unchanged) in the SEND cycle, so the receiver latches the value shown.
- Value on enviar cycle is ref_val as of that cycle; edits during HOLD impossible.
- Reset mid-SEND/HOLD: enviar drops immediately, FSM->IDLE, value returns to INIT_REF.
- Button held: exactly one event per press; no auto-repeat.
- MAX_REF < 255 saturation applies to all digits (e.g. MAX_REF=200, value 150, up on cent -> 200).

Test Plan:
(Bench uses DEB_CYCLES=4, HOLD_CYCLES=8.)
1. Reset, then press btn_up 3 times on units -> ref_val 0,1,2,3; enviar never high; digit_sel=001.
2. btn_left twice, btn_up 3 times (hundreds) from 3 -> 103, 203, then 255 (saturated); third btn_left keeps digit_sel=100.
3. ref_val=5, cursor tens, btn_down -> ref_val=0; btn_down again -> stays 0.
4. ref_val=123, press btn_ok and hold 30 cycles -> enviar high exactly one cycle with ref_val=123; busy high until ok released and >=8 cycles elapsed; btn_up pressed during HOLD -> ref_val remains 123.
5. btn_ok and btn_up rising in the same cycle -> one enviar pulse, ref_val unchanged; glitch on btn_up shorter than 4 cycles -> no event.
6. Assert rst during HOLD with ref_val=77 -> enviar=0, busy=0, ref_val=INIT_REF, digit_sel=001 immediately (asynchronously).

Source files
------------

// File: rtl/ref_entry.sv
// ---------------------------------------------------------------------------
// ref_entry
//   Pushbutton front end for the servo reference. Five raw buttons are
//   synchronized and debounced. Each debounced press becomes a one-cycle
//   event. The operator edits an 8-bit value one decimal digit at a time,
//   and the value saturates to 0..MAX_REF. OK issues a one-cycle send strobe,
//   followed by a lockout window.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   btn_up     raw button: add weight of the selected digit
//   btn_down   raw button: subtract weight of the selected digit
//   btn_left   raw button: move cursor toward hundreds
//   btn_right  raw button: move cursor toward units
//   btn_ok     raw button: send current value
//   ref_val    edited reference value (8 bits)
//   enviar     one-cycle send strobe
//   digit_sel  one-hot cursor {cent,dec,uni}
//   busy       high while sending and during the post-send lockout
//
// Strobe semantics: enviar is high for exactly one clk cycle. ref_val is
// guaranteed unchanged in that cycle, so the receiver may latch ref_val
// whenever enviar is high. There is no back-pressure.
// ---------------------------------------------------------------------------
module ref_entry #(
  parameter int DEB_CYCLES  = 500000,
  parameter int HOLD_CYCLES = 16,
  parameter int MAX_REF     = 255,
  parameter int INIT_REF    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_ok,
  output logic [7:0] ref_val,
  output logic       enviar,
  output logic [2:0] digit_sel,
  output logic       busy
);

  // Button index within the packed button vectors.
  localparam int B_UP = 0;
  localparam int B_DN = 1;
  localparam int B_LF = 2;
  localparam int B_RT = 3;
  localparam int B_OK = 4;

  localparam int CW  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES + 1)  : 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [CW-1:0]  DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [8:0]     MAX9      = 9'(MAX_REF);
  localparam logic [7:0]     INIT8     = 8'(INIT_REF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    deb;
  logic [4:0]    deb_d;
  logic [4:0]    evt;
  logic [CW-1:0] cnt [5];

  assign raw = {btn_ok, btn_right, btn_left, btn_down, btn_up};

  // -------------------------------------------------------------------------
  // Synchronize, debounce and edge-detect all five buttons.
  // The counter runs only while the synchronized level differs from the
  // accepted level. Any return to the accepted level restarts the counter.
  // The new level is accepted once it has been stable for DEB_CYCLES cycles.
  // The event is registered, so it lands one cycle after the accepted level
  // rises. Press-to-event latency is therefore 2 + DEB_CYCLES + 1 cycles.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      evt   <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      evt   <= deb & ~deb_d;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DEB_LAST) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Digit arithmetic. The math is done in 9 bits so that saturation needs
  // no wrap detection.
  // -------------------------------------------------------------------------
  logic [8:0] weight;
  logic [8:0] sum9;
  logic [7:0] up_val;
  logic [7:0] dn_val;

  always_comb begin
    weight = 9'd1;
    case (digit_sel)
      3'b100:  weight = 9'd100;
      3'b010:  weight = 9'd10;
      default: weight = 9'd1;
    endcase
    sum9   = {1'b0, ref_val} + weight;
    up_val = (sum9 > MAX9) ? MAX9[7:0] : sum9[7:0];
    dn_val = ({1'b0, ref_val} < weight) ? 8'd0 : 8'(({1'b0, ref_val} - weight));
  end

  // -------------------------------------------------------------------------
  // Control FSM. All outputs are registered.
  // In IDLE, events are served with the priority ok > up > down > left > right.
  // Only the winning event is acted on; the others are discarded.
  // Any event that fires in SEND or HOLD is dropped.
  // -------------------------------------------------------------------------
  state_t         state;
  logic [HCW-1:0] hcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ref_val   <= INIT8;
      digit_sel <= 3'b001;
      enviar    <= 1'b0;
      busy      <= 1'b0;
      hcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          enviar <= 1'b0;
          busy   <= 1'b0;
          if (evt[B_OK]) begin
            state  <= SEND;
            enviar <= 1'b1;
            busy   <= 1'b1;
          end else if (evt[B_UP]) begin
            ref_val <= up_val;
          end else if (evt[B_DN]) begin
            ref_val <= dn_val;
          end else if (evt[B_LF]) begin
            digit_sel <= (digit_sel == 3'b001) ? 3'b010 : 3'b100;
          end else if (evt[B_RT]) begin
            digit_sel <= (digit_sel == 3'b100) ? 3'b010 : 3'b001;
          end
        end
        SEND: begin
          enviar <= 1'b0;
          busy   <= 1'b1;
          hcnt   <= '0;
          state  <= HOLD;
        end
        HOLD: begin
          busy <= 1'b1;
          if (hcnt != HOLD_LAST) begin
            hcnt <= hcnt + 1'b1;
          end else if (!deb[B_OK]) begin
            // Stay locked until OK is released, so one long press never
            // produces a second send.
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          enviar <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ref_entry.sv
// ---------------------------------------------------------------------------
// tb_ref_entry
//   Directed bench for ref_entry, run with DEB_CYCLES=4 and HOLD_CYCLES=8.
//   Buttons are driven on the falling edge and outputs are sampled on the
//   falling edge. Every value sent is compared against exp_q.
// ---------------------------------------------------------------------------
module tb_ref_entry;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;   // {ok, right, left, down, up}
  logic [7:0] ref_val;
  logic       enviar;
  logic [2:0] digit_sel;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int env_cnt = 0;
  logic [7:0] exp_q[$];

  ref_entry #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD),
    .MAX_REF    (255),
    .INIT_REF   (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn[0]),
    .btn_down (btn[1]),
    .btn_left (btn[2]),
    .btn_right(btn[3]),
    .btn_ok   (btn[4]),
    .ref_val  (ref_val),
    .enviar   (enviar),
    .digit_sel(digit_sel),
    .busy     (busy)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drivers. Each press outlasts the event latency, then the button is
  // released and the release is allowed to settle.
  task automatic press(input int idx);
    btn[idx] = 1'b1;
    tick(DEB + 6);
    btn[idx] = 1'b0;
    tick(DEB + 6);
  endtask

  task automatic press_n(input int idx, input int n);
    for (int k = 0; k < n; k++) press(idx);
  endtask

  // Scoreboard for sends, sampled 1 ns after the rising edge.
  always @(posedge clk) begin
    #1;
    if (enviar === 1'b1) begin
      env_cnt++;
      if (exp_q.size() == 0) begin
        check("enviar_unexpected", 1, 0);
      end else begin
        check("enviar_value", {24'd0, ref_val}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset state.
    tick(3);
    check("rst_ref", ref_val, 0);
    check("rst_enviar", enviar, 0);
    check("rst_digit", digit_sel, 3'b001);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    // 1: three ups on units.
    press(0); check("t1_up1", ref_val, 1);
    press(0); check("t1_up2", ref_val, 2);
    press(0); check("t1_up3", ref_val, 3);
    check("t1_digit", digit_sel, 3'b001);
    check("t1_no_send", env_cnt, 0);

    // 2: move to hundreds and saturate.
    press(2); check("t2_left1", digit_sel, 3'b010);
    press(2); check("t2_left2", digit_sel, 3'b100);
    press(0); check("t2_up103", ref_val, 103);
    press(0); check("t2_up203", ref_val, 203);
    press(0); check("t2_sat255", ref_val, 255);
    press(2); check("t2_left_stop", digit_sel, 3'b100);

    // 3: down to 5 on tens, then clamp at 0.
    press_n(1, 2); check("t3_down55", ref_val, 55);
    press(3); check("t3_right", digit_sel, 3'b010);
    press_n(1, 5); check("t3_down5", ref_val, 5);
    press(1); check("t3_clamp0", ref_val, 0);
    press(1); check("t3_stay0", ref_val, 0);

    // 4: build 123, then send with OK held.
    press(2);
    press(0);
    press(3);
    press_n(0, 2);
    press(3);
    press_n(0, 3);
    check("t4_val123", ref_val, 123);
    exp_q.push_back(8'd123);
    btn[4] = 1'b1;
    tick(12);
    check("t4_busy_sent", busy, 1);
    check("t4_one_send", env_cnt, 1);
    press(0);                     // dropped during HOLD
    tick(2);
    check("t4_hold_val", ref_val, 123);
    check("t4_busy_held", busy, 1);
    btn[4] = 1'b0;
    tick(3);
    check("t4_busy_release", busy, 1);
    tick(10);
    check("t4_idle", busy, 0);
    check("t4_send_total", env_cnt, 1);

    // 5: OK and UP together, then a short glitch, then right at units.
    exp_q.push_back(8'd123);
    btn[4] = 1'b1;
    btn[0] = 1'b1;
    tick(20);
    btn[4] = 1'b0;
    btn[0] = 1'b0;
    tick(20);
    check("t5_ok_wins_val", ref_val, 123);
    check("t5_send_total", env_cnt, 2);
    check("t5_idle", busy, 0);
    btn[0] = 1'b1;
    tick(DEB - 1);
    btn[0] = 1'b0;
    tick(15);
    check("t5_glitch", ref_val, 123);
    press(3); check("t5_right_stop", digit_sel, 3'b001);

    // 6: build 77, send, reset during HOLD.
    press(2);
    press_n(1, 5);
    press(3);
    press_n(0, 4);
    check("t6_val77", ref_val, 77);
    exp_q.push_back(8'd77);
    btn[4] = 1'b1;
    tick(14);
    check("t6_busy_hold", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_enviar", enviar, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ref", ref_val, 0);
    check("t6_rst_digit", digit_sel, 3'b001);
    btn[4] = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("t6_after_ref", ref_val, 0);
    check("t6_after_busy", busy, 0);
    check("t6_send_total", env_cnt, 3);
    press(0); check("t6_up_after", ref_val, 1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
